// File: rtl/lab2_proc_fetch_inst_buf_if.sv
// Handshake bundle between F imem port, the fetch buffer and D.
// master: F/D side driving requests; slave: the buffer itself.
interface lab2_proc_fetch_inst_buf_if;
    logic        req_sent;
    logic [31:0] req_pc;
    logic        inflight_full;
    logic        imemresp_val;
    logic        imemresp_rdy;
    logic [31:0] imemresp_data;
    logic        squash;
    logic        inst_val_D;
    logic        inst_rdy_D;
    logic [31:0] inst_D;
    logic [31:0] pc_D;

    modport master (
        output req_sent, req_pc, imemresp_val,
        output imemresp_data, squash, inst_rdy_D,
        input  inflight_full, imemresp_rdy,
        input  inst_val_D, inst_D, pc_D
    );

    modport slave (
        input  req_sent, req_pc, imemresp_val,
        input  imemresp_data, squash, inst_rdy_D,
        output inflight_full, imemresp_rdy,
        output inst_val_D, inst_D, pc_D
    );
endinterface

// File: rtl/lab2_proc_fetch_inst_buf.sv
// Fetch-to-decode buffer: pairs imem responses with request PCs,
// queues {pc,inst} for D and drops responses made stale by squash.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   req_sent/req_pc in, inflight_full out, imemresp_val/data in,
//   imemresp_rdy out, squash in, inst_val_D/inst_D/pc_D out,
//   inst_rdy_D in.
// Macro LAB2_PROC_FETCH_BUF_BYPASS_EN: same-cycle response bypass
// onto D when the buffer is empty.
module lab2_proc_fetch_inst_buf #(
    parameter int p_num_entries  = 2,
    parameter int p_max_inflight = 2
) (
    input logic clk,
    input logic reset,
    lab2_proc_fetch_inst_buf_if.slave bus
);

    localparam int CW = $clog2(p_max_inflight + 1);
    localparam int OW = CW + 1;
    localparam int PW = (p_max_inflight > 1) ?
                        $clog2(p_max_inflight) : 1;
    localparam int BW = (p_num_entries > 1) ?
                        $clog2(p_num_entries) : 1;
    localparam int NW = $clog2(p_num_entries + 1);

    logic [31:0]   pcq [p_max_inflight];
    logic [PW-1:0] phead;
    logic [PW-1:0] ptail;
    logic [CW-1:0] pc_cnt;
    logic [CW-1:0] drop_cnt;

    logic [31:0]   bpc   [p_num_entries];
    logic [31:0]   binst [p_num_entries];
    logic [BW-1:0] bhead;
    logic [BW-1:0] btail;
    logic [NW-1:0] bcnt;

    logic          buf_empty;
    logic          buf_full;
    logic          dropping;
    logic          resp_fire;
    logic          live;
    logic          byp;
    logic          enq;
    logic          deq;
    logic [31:0]   head_pc;
    logic [OW-1:0] outstanding;

    function automatic logic [PW-1:0] pnext(
        input logic [PW-1:0] p
    );
        if (p == PW'(p_max_inflight - 1))
            return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [BW-1:0] bnext(
        input logic [BW-1:0] p
    );
        if (p == BW'(p_num_entries - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign buf_empty = (bcnt == '0);
    assign buf_full  = (bcnt == NW'(p_num_entries));
    assign dropping  = (drop_cnt != '0);
    assign head_pc   = pcq[phead];

    assign bus.imemresp_rdy = dropping || !buf_full;
    assign resp_fire = bus.imemresp_val && bus.imemresp_rdy;
    assign live      = resp_fire && !dropping;

    assign outstanding = {1'b0, pc_cnt} + {1'b0, drop_cnt};
    assign bus.inflight_full =
        (outstanding == OW'(p_max_inflight));

    always_comb begin
        byp = 1'b0;
`ifdef LAB2_PROC_FETCH_BUF_BYPASS_EN
        byp = buf_empty && live && !bus.squash;
`endif
    end

    // Buffer head wins; bypass only shows through when empty.
    always_comb begin
        bus.inst_val_D = !buf_empty || byp;
        bus.inst_D     = '0;
        bus.pc_D       = '0;
        if (!buf_empty) begin
            bus.inst_D = binst[bhead];
            bus.pc_D   = bpc[bhead];
        end else if (byp) begin
            bus.inst_D = bus.imemresp_data;
            bus.pc_D   = head_pc;
        end
    end

    assign deq = !buf_empty && bus.inst_rdy_D;
    // A bypassed response D consumed now never needs a slot.
    assign enq = live && !bus.squash &&
                 !(byp && bus.inst_rdy_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            phead    <= '0;
            ptail    <= '0;
            pc_cnt   <= '0;
            drop_cnt <= '0;
            bhead    <= '0;
            btail    <= '0;
            bcnt     <= '0;
        end else if (bus.squash) begin
            // Everything in flight becomes stale; the redirect
            // fetch issued this cycle is the only live entry.
            bhead    <= '0;
            btail    <= '0;
            bcnt     <= '0;
            drop_cnt <= drop_cnt + pc_cnt - CW'(resp_fire);
            phead    <= '0;
            ptail    <= bus.req_sent ? pnext('0) : '0;
            pc_cnt   <= CW'(bus.req_sent);
        end else begin
            if (bus.req_sent)
                ptail <= pnext(ptail);
            if (live)
                phead <= pnext(phead);
            pc_cnt <= pc_cnt + CW'(bus.req_sent) - CW'(live);
            if (resp_fire && dropping)
                drop_cnt <= drop_cnt - 1'b1;
            if (enq)
                btail <= bnext(btail);
            if (deq)
                bhead <= bnext(bhead);
            bcnt <= bcnt + NW'(enq) - NW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.req_sent)
            pcq[bus.squash ? '0 : ptail] <= bus.req_pc;
        if (enq) begin
            bpc[btail]   <= head_pc;
            binst[btail] <= bus.imemresp_data;
        end
    end

    a_req_full: assert property (
        @(posedge clk) disable iff (reset)
        !(bus.req_sent && bus.inflight_full));

    a_orphan: assert property (
        @(posedge clk) disable iff (reset)
        !(resp_fire && pc_cnt == '0 && drop_cnt == '0));

endmodule
